// File: rtl/cam_init_sequencer.sv
// Camera power-up sequencer: sequences cam_pwdn/cam_rstn, then replays a ROM register
// table to the SCCB master with NACK/timeout retry and done/error reporting.
module cam_init_sequencer #(
   parameter int unsigned PWDN_CYCLES   = 25000,
   parameter int unsigned RST_CYCLES    = 25000,
   parameter int unsigned SETTLE_CYCLES = 75000,
   parameter int unsigned ACK_TIMEOUT   = 100000,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned N_REGS        = 64,
   parameter logic [7:0]  DEV_ADDR      = 8'h42,
   parameter bit          AUTO_START    = 1'b1,
   localparam int unsigned ADDR_W       = $clog2(N_REGS)
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   input  logic              start,
   output logic              cam_pwdn,
   output logic              cam_rstn,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              wr_req,
   output logic [7:0]        wr_dev,
   output logic [7:0]        wr_reg,
   output logic [7:0]        wr_data,
   input  logic              wr_ack,
   input  logic              wr_nack,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] err_idx
);

   localparam int unsigned MAX_A   = (PWDN_CYCLES > RST_CYCLES) ? PWDN_CYCLES : RST_CYCLES;
   localparam int unsigned MAX_B   = (SETTLE_CYCLES > ACK_TIMEOUT) ? SETTLE_CYCLES : ACK_TIMEOUT;
   localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam int unsigned IDX_W   = ADDR_W + 1;
   localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [15:0] END_WORD = 16'hFFFF;
   localparam logic [15:0] DLY_WORD = 16'hFFF0;

   typedef enum logic [3:0] {
      S_IDLE, S_PWDN, S_RSTLOW, S_SETTLE, S_FETCH, S_DECODE,
      S_ISSUE, S_WAIT_ACK, S_GAP, S_DELAY, S_DONE, S_ERROR
   } state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [IDX_W-1:0]   idx, idx_n;
   logic [RTY_W-1:0]   retry, retry_n;
   logic               auto_pend, auto_n;
   logic               pwdn_n, rstn_n, req_n, done_n, error_n;
   logic [7:0]         reg_n, data_n;
   logic [ADDR_W-1:0]  addr_n, err_idx_n;

   assign wr_dev = DEV_ADDR;

   // State and registered outputs
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state     <= S_IDLE;
         cnt       <= '0;
         idx       <= '0;
         retry     <= '0;
         auto_pend <= AUTO_START;
         cam_pwdn  <= 1'b1;
         cam_rstn  <= 1'b0;
         rom_addr  <= '0;
         wr_req    <= 1'b0;
         wr_reg    <= '0;
         wr_data   <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_idx   <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         retry     <= retry_n;
         auto_pend <= auto_n;
         cam_pwdn  <= pwdn_n;
         cam_rstn  <= rstn_n;
         rom_addr  <= addr_n;
         wr_req    <= req_n;
         wr_reg    <= reg_n;
         wr_data   <= data_n;
         done      <= done_n;
         error     <= error_n;
         err_idx   <= err_idx_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      retry_n   = retry;
      auto_n    = auto_pend;
      req_n     = wr_req;
      reg_n     = wr_reg;
      data_n    = wr_data;
      done_n    = done;
      error_n   = error;
      err_idx_n = err_idx;

      case (state)
         S_IDLE: begin
            auto_n = 1'b0;
            if (start || auto_pend) begin
               state_n = S_PWDN;
               cnt_n   = '0;
            end
         end
         S_PWDN: begin
            if (cnt == CNT_W'(PWDN_CYCLES - 1)) begin
               state_n = S_RSTLOW;
               cnt_n   = '0;
            end else cnt_n = cnt + CNT_W'(1);
         end
         S_RSTLOW: begin
            if (cnt == CNT_W'(RST_CYCLES - 1)) begin
               state_n = S_SETTLE;
               cnt_n   = '0;
            end else cnt_n = cnt + CNT_W'(1);
         end
         S_SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
               state_n = S_FETCH;
               cnt_n   = '0;
               idx_n   = '0;
               retry_n = '0;
            end else cnt_n = cnt + CNT_W'(1);
         end
         S_FETCH: state_n = S_DECODE;
         S_DECODE: begin
            if (rom_data == END_WORD || idx == IDX_W'(N_REGS)) begin
               state_n = S_DONE;
               done_n  = 1'b1;
            end else if (rom_data == DLY_WORD) begin
               state_n = S_DELAY;
               cnt_n   = '0;
            end else begin
               reg_n   = rom_data[15:8];
               data_n  = rom_data[7:0];
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            req_n   = 1'b1;
            cnt_n   = '0;
            state_n = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            // A NACK and a timeout are handled identically
            if (wr_ack || cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
               req_n = 1'b0;
               if (wr_ack && !wr_nack) begin
                  idx_n   = idx + IDX_W'(1);
                  retry_n = '0;
                  state_n = S_FETCH;
               end else if (retry < RTY_W'(MAX_RETRY)) begin
                  retry_n = retry + RTY_W'(1);
                  state_n = S_GAP;
               end else begin
                  error_n   = 1'b1;
                  err_idx_n = ADDR_W'(idx);
                  state_n   = S_ERROR;
               end
            end else cnt_n = cnt + CNT_W'(1);
         end
         S_GAP: state_n = S_ISSUE;
         S_DELAY: begin
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
               idx_n   = idx + IDX_W'(1);
               cnt_n   = '0;
               state_n = S_FETCH;
            end else cnt_n = cnt + CNT_W'(1);
         end
         S_DONE, S_ERROR: begin
            if (start) begin
               done_n  = 1'b0;
               error_n = 1'b0;
               cnt_n   = '0;
               state_n = S_PWDN;
            end
         end
         default: state_n = S_IDLE;
      endcase

      pwdn_n = (state_n == S_IDLE) || (state_n == S_PWDN);
      rstn_n = !((state_n == S_IDLE) || (state_n == S_PWDN) || (state_n == S_RSTLOW));
      addr_n = ADDR_W'(idx_n);
   end

endmodule

// File: tb/tb_cam_init_sequencer.sv
// Bench for cam_init_sequencer: event-time reference model of the power-up and table
// walk, a randomised SCCB responder, and directed scenarios with literal pins.
module tb_cam_init_sequencer;

   localparam int unsigned P = 20, R = 15, S = 12, T = 30, MAXR = 3, N = 16;
   localparam int unsigned AW = $clog2(N);
   localparam int unsigned NEVER = 32'hFFFF_FFFF;
   localparam logic [15:0] W_END = 16'hFFFF, W_DLY = 16'hFFF0;
   localparam int R_ACK = 0, R_NACK = 1, R_TMO = 2, R_STRAY = 3;

   logic          clk = 1'b0;
   logic          rst_n, start, wr_ack, wr_nack;
   logic          cam_pwdn, cam_rstn, wr_req, done, error;
   logic [AW-1:0] rom_addr, err_idx;
   logic [15:0]   rom_data;
   logic [7:0]    wr_dev, wr_reg, wr_data;

   cam_init_sequencer #(
      .PWDN_CYCLES(P), .RST_CYCLES(R), .SETTLE_CYCLES(S), .ACK_TIMEOUT(T),
      .MAX_RETRY(MAXR), .N_REGS(N), .DEV_ADDR(8'h42), .AUTO_START(1'b1)
   ) dut (
      .PCLK(clk), .PRESETN(rst_n), .start(start),
      .cam_pwdn(cam_pwdn), .cam_rstn(cam_rstn),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .wr_req(wr_req), .wr_dev(wr_dev), .wr_reg(wr_reg), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_nack(wr_nack),
      .done(done), .error(error), .err_idx(err_idx)
   );

   always #5 clk = ~clk;

   logic [15:0] rom [N];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int unsigned n_chk = 0, n_pass = 0;
   int unsigned cyc = 0;
   bit          cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: absolute edge numbers of each upcoming event
   bit          m_idle, m_run, m_auto, m_done, m_err, m_req;
   int unsigned m_err_idx, m_entry, m_retry, m_pf, m_rr, m_req_at, m_fin_at, m_rise;
   logic [7:0]  m_reg, m_data;

   task automatic m_reset();
      m_idle = 1; m_run = 0; m_auto = 1; m_done = 0; m_err = 0; m_req = 0;
      m_err_idx = 0; m_entry = 0; m_retry = 0; m_pf = 0; m_rr = NEVER;
      m_req_at = NEVER; m_fin_at = NEVER; m_rise = 0; m_reg = '0; m_data = '0;
   endtask

   // e: edge at which entry i is being fetched; fetch+decode+issue = 3 edges to wr_req
   task automatic m_walk(input int unsigned e0, input int unsigned i0);
      int unsigned e, i;
      e = e0; i = i0;
      forever begin
         if (i >= N || rom[i] == W_END) begin
            m_fin_at = e + 2;
            return;
         end
         if (rom[i] == W_DLY) begin
            e = e + 2 + S;
            i++;
         end else begin
            m_req_at = e + 3; m_entry = i;
            m_reg = rom[i][15:8]; m_data = rom[i][7:0];
            return;
         end
      end
   endtask

   task automatic m_fail(input int unsigned c);
      if (m_retry < MAXR) begin
         m_retry++;
         m_req_at = c + 2;
      end else begin
         m_err = 1; m_err_idx = m_entry; m_run = 0;
      end
   endtask

   task automatic m_step(input int unsigned c);
      if (!m_run && (start || (m_idle && m_auto))) begin
         m_run = 1; m_idle = 0; m_auto = 0; m_done = 0; m_err = 0; m_retry = 0;
         m_pf = c + P; m_rr = c + P + R;
         m_req_at = NEVER; m_fin_at = NEVER;
         m_walk(c + P + R + S, 0);
      end else if (m_run) begin
         if (m_fin_at == c) begin
            m_done = 1; m_run = 0; m_fin_at = NEVER;
         end
         if (m_req_at == c) begin
            m_req = 1; m_rise = c; m_req_at = NEVER;
         end else if (m_req) begin
            if (wr_ack) begin
               m_req = 0;
               if (!wr_nack) begin
                  m_retry = 0;
                  m_walk(c, m_entry + 1);
               end else m_fail(c);
            end else if (c == m_rise + T) begin
               m_req = 0;
               m_fail(c);
            end
         end
      end
      if (m_idle) m_auto = 0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else begin
         cyc++;
         m_step(cyc);
      end
   end

   // Compare process and write/pulse monitor
   logic [23:0] wlog [$];
   int unsigned wrise [$], plen [$];
   int unsigned hi_len = 0, pwdn_fall_cyc = 0, rstn_rise_cyc = 0;
   logic req_q = 1'b0, pwdn_q = 1'b1, rstn_q = 1'b0;

   always @(negedge clk) begin : cmp
      logic ep, er;
      ep = m_idle ? 1'b1 : (cyc < m_pf);
      er = m_idle ? 1'b0 : (cyc >= m_rr);
      if (cmp_en) begin
         chk("cam_pwdn", 32'(cam_pwdn), 32'(ep));
         chk("cam_rstn", 32'(cam_rstn), 32'(er));
         chk("wr_req", 32'(wr_req), 32'(m_req));
         chk("done", 32'(done), 32'(m_done));
         chk("error", 32'(error), 32'(m_err));
         if (m_err) chk("err_idx", 32'(err_idx), m_err_idx);
         if (m_req) begin
            chk("wr_dev", 32'(wr_dev), 32'h42);
            chk("wr_reg", 32'(wr_reg), 32'(m_reg));
            chk("wr_data", 32'(wr_data), 32'(m_data));
         end
      end
      if (wr_req && !req_q) begin
         wlog.push_back({wr_dev, wr_reg, wr_data});
         wrise.push_back(cyc);
      end
      if (wr_req) hi_len++;
      else if (req_q) begin
         plen.push_back(hi_len);
         hi_len = 0;
      end
      if (pwdn_q && !cam_pwdn) pwdn_fall_cyc = cyc;
      if (!rstn_q && cam_rstn) rstn_rise_cyc = cyc;
      req_q = wr_req; pwdn_q = cam_pwdn; rstn_q = cam_rstn;
   end

   // SCCB master stand-in: per-request response from the plan queue or at random
   int plan [$];
   int pct_nack = 0, pct_tmo = 0;

   task automatic respond();
      int mode, r, dly;
      if (plan.size() > 0) mode = plan.pop_front();
      else begin
         r = int'($urandom_range(99));
         if (r < pct_tmo) mode = (r % 2 == 0) ? R_STRAY : R_TMO;
         else if (r < pct_tmo + pct_nack) mode = R_NACK;
         else mode = R_ACK;
      end
      if (mode >= R_TMO) begin
         for (int n = 0; n < int'(T) + 4 && wr_req; n++) begin
            @(posedge clk); #1;
         end
         if (mode == R_STRAY) begin
            wr_ack = 1'b1; wr_nack = 1'b0;
            @(posedge clk); #1;
            wr_ack = 1'b0;
         end
      end else begin
         dly = int'($urandom_range(3));
         repeat (dly) begin @(posedge clk); #1; end
         wr_ack = 1'b1; wr_nack = (mode == R_NACK);
         @(posedge clk); #1;
         wr_ack = 1'b0; wr_nack = 1'b0;
      end
   endtask

   initial begin : responder
      wr_ack = 1'b0; wr_nack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (wr_req) respond();
      end
   end

   task automatic clear_rom();
      for (int i = 0; i < int'(N); i++) rom[i] = W_END;
   endtask

   task automatic load_random();
      int r;
      for (int i = 0; i < int'(N); i++) begin
         r = int'($urandom_range(99));
         if (r < 8) rom[i] = W_DLY;
         else if (r < 14 && i > 2) rom[i] = W_END;
         else rom[i] = 16'($urandom_range(32'hFEFF));
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int n;
      n = 0;
      while (!(done || error) && n < budget) begin
         @(negedge clk); n++;
      end
      chk("run_finished", 32'(done || error), 32'h1);
   endtask

   int unsigned rel_cyc;
   int          n31, nw;

   initial begin : main
      rst_n = 1'b1; start = 1'b0;
      clear_rom();
      rom[0] = 16'h1280; rom[1] = W_DLY; rom[2] = 16'h1101; rom[3] = W_END;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      cmp_en = 1'b1;
      #1 rst_n = 1'b1;
      rel_cyc = cyc;

      // Auto-start power-up and a table with a delay entry
      wait_end(2000);
      chk("t1_pwdn_fall", pwdn_fall_cyc - rel_cyc, 32'd21);
      chk("t1_rstlow_len", rstn_rise_cyc - pwdn_fall_cyc, 32'd15);
      chk("t1_first_req", (wrise.size() > 0) ? wrise[0] - rel_cyc : 0, 32'd51);
      chk("t1_nwrites", wlog.size(), 32'd2);
      chk("t1_write0", 32'(wlog[0]), 32'h421280);
      chk("t1_write1", 32'(wlog[1]), 32'h421101);
      chk("t1_delay_gap", 32'((wrise.size() > 1) && (wrise[1] - wrise[0] >= S)), 32'h1);
      chk("t1_done", 32'(done), 32'h1);

      // Entry 1 NACKed twice, then accepted
      clear_rom();
      rom[0] = 16'h3001; rom[1] = 16'h3102; rom[2] = 16'h3203;
      plan = '{R_ACK, R_NACK, R_NACK, R_ACK, R_ACK};
      wlog.delete(); wrise.delete();
      pulse_start();
      wait_end(2000);
      n31 = 0;
      foreach (wlog[i]) if (wlog[i][15:8] == 8'h31) n31++;
      chk("t2_entry1_pulses", n31, 32'd3);
      chk("t2_nwrites", wlog.size(), 32'd5);
      chk("t2_done", 32'(done), 32'h1);

      // Entry 2 NACKed four times: retries exhausted
      clear_rom();
      rom[0] = 16'h4001; rom[1] = 16'h4102; rom[2] = 16'h4203; rom[3] = 16'h4304;
      plan = '{R_ACK, R_ACK, R_NACK, R_NACK, R_NACK, R_NACK};
      wlog.delete(); wrise.delete();
      pulse_start();
      wait_end(2000);
      repeat (50) @(negedge clk);
      chk("t3_error", 32'(error), 32'h1);
      chk("t3_err_idx", 32'(err_idx), 32'd2);
      chk("t3_done", 32'(done), 32'h0);
      chk("t3_nwrites", wlog.size(), 32'd6);

      // Withheld acks: timeout, stray late ack, retry
      clear_rom();
      rom[0] = 16'h5001; rom[1] = W_DLY; rom[2] = 16'h5102;
      plan = '{R_STRAY, R_ACK, R_TMO, R_NACK, R_ACK};
      wlog.delete(); wrise.delete(); plen.delete();
      pulse_start();
      wait_end(3000);
      chk("t4_timeout_len", (plen.size() > 0) ? plen[0] : 0, T);
      chk("t4_nwrites", wlog.size(), 32'd5);
      chk("t4_done", 32'(done), 32'h1);

      // Random tables and responses
      for (int k = 0; k < 8; k++) begin
         load_random();
         pct_nack = 20;
         pct_tmo  = (k % 2 == 1) ? 8 : 0;
         pulse_start();
         wait_end(20000);
      end

      // Reset while a write is outstanding
      pct_nack = 0; pct_tmo = 0;
      clear_rom();
      rom[0] = 16'h6001; rom[1] = 16'h6102;
      plan = '{R_TMO};
      pulse_start();
      nw = 0;
      while (!wr_req && nw < 500) begin @(negedge clk); nw++; end
      chk("t6_req_seen", 32'(wr_req), 32'h1);
      repeat (3) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_req", 32'(wr_req), 32'h0);
      chk("t6_rst_pwdn", 32'(cam_pwdn), 32'h1);
      chk("t6_rst_rstn", 32'(cam_rstn), 32'h0);
      repeat (2) @(posedge clk);
      plan.delete(); wlog.delete(); wrise.delete();
      #1 rst_n = 1'b1;
      wait_end(2000);
      chk("t6_nwrites", wlog.size(), 32'd2);
      chk("t6_first_write", 32'(wlog[0]), 32'h426001);
      chk("t6_done", 32'(done), 32'h1);

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: got no completion, want finish before cycle %0d", cyc);
      $fatal(1);
   end

endmodule
